gin_buffered: RTL and testbench
===============================

// Module: gin_buffered
// PURPOSE
//  Next-generation global input network: multicasts one input word to every PE whose (YID,XID) matches
//  the transaction tag, with a per-row FIFO decoupling the Y stage from the X stage so a stalled row
//  no longer blocks delivery to other rows once its entry is queued. Sits between the ifmap/filter
//  SRAM reader and the PE array; IDs are loaded by the controller over the same scan chains as before.
// PARAMETERS
//  DATA_W      32  payload width
//  ROWS         6  PE rows (Y slaves)
//  COLS         8  PEs per row (X slaves)
//  YID_W        4  row ID / tag_y width
//  XID_W        5  column ID / tag_x width
//  FIFO_DEPTH   4  entries per row FIFO, power of two >= 2
// PORTS
//  clk          in   1              clock, rising edge
//  rst          in   1              synchronous reset, active-low
//  in_valid     in   1              input word valid
//  in_ready     out  1              input word accepted when in_valid&in_ready
//  in_data      in   DATA_W         input payload
//  tag_y        in   YID_W          row tag, sampled with in_data
//  tag_x        in   XID_W          column tag, sampled with in_data
//  set_yid      in   1              shift yid_scan_in into row-ID chain
//  yid_scan_in  in   YID_W          row-ID chain input
//  set_xid      in   1              shift xid_scan_in into PE-ID chain
//  xid_scan_in  in   XID_W          PE-ID chain input
//  pe_ready     in   ROWS*COLS      PE k=r*COLS+c can accept
//  pe_valid     out  ROWS*COLS      word delivered to PE k this cycle
//  pe_data      out  ROWS*DATA_W    row r payload, slice [r*DATA_W +: DATA_W]
//  busy         out  1              any row FIFO non-empty
//  drop_cnt     out  16             saturating count of dropped words
// BEHAVIOUR
//  Reset (rst==0 at edge): all FIFOs empty, all IDs 0, drop_cnt 0; hence pe_valid 0, busy 0, pe_data 0.
//  ID chains: set_yid: yid[0]<=yid_scan_in, yid[r]<=yid[r-1]. set_xid: xid[0]<=xid_scan_in,
//   xid[k]<=xid[k-1], k flat index 0..ROWS*COLS-1. First value shifted ends at highest index.
//  in_ready = !set_yid & !set_xid & AND over r of (!row_hit[r] | !full[r]); row_hit[r]=(yid[r]==tag_y).
//   Combinational in tags/IDs/full only; never depends on in_valid. No pop-through: full row blocks even if
//   popping same cycle.
//  Accept: push {tag_x,in_data} into every hit row FIFO in the same cycle (all-or-nothing multicast).
//   Accept with zero hit rows: word consumed, drop_cnt+1.
//  Row drain (each row independent, every cycle): head {htag,hdata}; pe_hit[c]=(xid[r*COLS+c]==htag);
//   go[r] = !empty[r] & AND over c of (!pe_hit[c] | pe_ready[r*COLS+c]).
//   pe_valid[r*COLS+c] = go[r] & pe_hit[c]; pop head when go[r]. pe_valid never asserted with ready low.
//   Head with no hit PE: go=1, popped with no pe_valid, drop_cnt+1.
//   pe_data slice r = hdata when non-empty, else 0.
//  Drops from accept and rows in same cycle add together; drop_cnt saturates at 16'hFFFF.
//  Latency: word accepted at edge t drives pe_valid earliest in the cycle after t (FIFO is registered).
//  Throughput: 1 word/cycle per row with all targets ready; rows order-preserving, no cross-row order.
//  ID updates during drain apply immediately to head matching (controller shifts IDs only when !busy).
//  Pointers: wr/rd of log2(FIFO_DEPTH) bits wrap modulo depth; count 0..FIFO_DEPTH; full=(count==DEPTH).
//  Reset mid-operation discards queued words; no pe_valid in the cycle after reset.
// TESTING
//  Scan 6 row IDs 5,4,3,2,1,0 via set_yid -> yid[0]=0..yid[5]=5; same check on 48 XIDs.
//  Unicast tag_y=2,tag_x=3, data 0xA5, all ready -> pe_valid[19] one cycle later, pe_data slice2=0xA5.
//  Multicast: all XIDs in row 1 =0, tag_y=1,tag_x=0 -> pe_valid[15:8]=8'hFF same cycle; one pop.
//  Row1 PE9 ready=0, push 5 words to row1 -> 4 accepted, in_ready=0 on 5th; row0 traffic unaffected.
//  tag_y=15 matches no row -> in_ready=1, word consumed, drop_cnt=1; busy stays 0.
//  Fill row FIFO to 3, pull rst low 1 cycle -> busy=0, pe_valid=0, drop_cnt=0; then new word delivered.

Source files
------------

// File: rtl/gin_buffered.sv
// gin_buffered -- buffered global input network.
//
// Multicasts one input word to every PE whose (row ID, column ID) pair matches
// the word's (tag_y, tag_x). The Y stage pushes the word (with its X tag) into
// the FIFO of every matching row in one cycle. Each row then drains its FIFO
// head to the matching PEs on its own, so a stalled row does not hold up the
// others once the word has been queued.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   in_valid     input word valid
//   in_ready     input word accepted when in_valid & in_ready
//   in_data      input payload
//   tag_y        row tag of the input word
//   tag_x        column tag of the input word
//   set_yid      shift yid_scan_in into the row-ID chain
//   yid_scan_in  row-ID chain input
//   set_xid      shift xid_scan_in into the PE-ID chain
//   xid_scan_in  PE-ID chain input
//   pe_ready     PE k = r*COLS+c can accept
//   pe_valid     word delivered to PE k this cycle
//   pe_data      row r payload in slice [r*DATA_W +: DATA_W]
//   busy         any row FIFO non-empty
//   drop_cnt     saturating count of words that reached no PE

module gin_buffered #(
    parameter int DATA_W     = 32,
    parameter int ROWS       = 6,
    parameter int COLS       = 8,
    parameter int YID_W      = 4,
    parameter int XID_W      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [YID_W-1:0]       tag_y,
    input  logic [XID_W-1:0]       tag_x,
    input  logic                   set_yid,
    input  logic [YID_W-1:0]       yid_scan_in,
    input  logic                   set_xid,
    input  logic [XID_W-1:0]       xid_scan_in,
    input  logic [ROWS*COLS-1:0]   pe_ready,
    output logic [ROWS*COLS-1:0]   pe_valid,
    output logic [ROWS*DATA_W-1:0] pe_data,
    output logic                   busy,
    output logic [15:0]            drop_cnt
);

    localparam int NPE    = ROWS * COLS;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENT_W  = XID_W + DATA_W;
    // Up to one drop from the input plus one per row in the same cycle.
    localparam int DROP_W = $clog2(ROWS + 2);

    logic [YID_W-1:0] yid    [ROWS];
    logic [XID_W-1:0] xid    [NPE];
    logic [ENT_W-1:0] mem    [ROWS][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr [ROWS];
    logic [PTR_W-1:0] rd_ptr [ROWS];
    logic [CNT_W-1:0] count  [ROWS];

    logic [ROWS-1:0]   row_hit;
    logic [ROWS-1:0]   full;
    logic [ROWS-1:0]   empty;
    logic [ROWS-1:0]   push;
    logic [ROWS-1:0]   go;
    logic [ROWS-1:0]   row_drop;
    logic [NPE-1:0]    pe_hit;
    logic              accept;
    logic [DROP_W-1:0] drop_inc;
    logic [16:0]       drop_sum;

    // ------------------------------------------------------------------
    // Y stage: row match and accept
    // ------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_hit[r] = (yid[r] == tag_y);
            full[r]    = (count[r] == CNT_W'(FIFO_DEPTH));
            empty[r]   = (count[r] == '0);
        end
    end

    // A full target row blocks even if it pops this cycle; this keeps
    // in_ready free of any path through pe_ready.
    always_comb begin
        in_ready = !set_yid && !set_xid;
        for (int r = 0; r < ROWS; r++) begin
            if (row_hit[r] && full[r]) begin
                in_ready = 1'b0;
            end
        end
    end

    assign accept = in_valid && in_ready;
    assign push   = {ROWS{accept}} & row_hit;

    // ------------------------------------------------------------------
    // X stage: per-row head match and drain
    // ------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                pe_hit[r*COLS+c] =
                    (xid[r*COLS+c] == mem[r][rd_ptr[r]][ENT_W-1 -: XID_W]);
            end
        end
    end

    always_comb begin
        pe_valid = '0;
        pe_data  = '0;
        go       = '0;
        row_drop = '0;
        for (int r = 0; r < ROWS; r++) begin
            // Head leaves only when every PE it targets is ready, so a
            // multicast word reaches all its PEs in the same cycle.
            go[r] = !empty[r] &&
                    (&(~pe_hit[r*COLS +: COLS] | pe_ready[r*COLS +: COLS]));
            pe_valid[r*COLS +: COLS] = {COLS{go[r]}} & pe_hit[r*COLS +: COLS];
            row_drop[r] = go[r] && (pe_hit[r*COLS +: COLS] == '0);
            if (!empty[r]) begin
                pe_data[r*DATA_W +: DATA_W] = mem[r][rd_ptr[r]][DATA_W-1:0];
            end
        end
    end

    assign busy = |(~empty);

    // ------------------------------------------------------------------
    // Drop accounting
    // ------------------------------------------------------------------
    always_comb begin
        drop_inc = '0;
        if (accept && (row_hit == '0)) begin
            drop_inc = drop_inc + DROP_W'(1);
        end
        for (int r = 0; r < ROWS; r++) begin
            if (row_drop[r]) begin
                drop_inc = drop_inc + DROP_W'(1);
            end
        end
        drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);
    end

    // ------------------------------------------------------------------
    // State: ID chains, FIFO pointers, drop counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < ROWS; r++) begin
                yid[r]    <= '0;
                wr_ptr[r] <= '0;
                rd_ptr[r] <= '0;
                count[r]  <= '0;
            end
            for (int k = 0; k < NPE; k++) begin
                xid[k] <= '0;
            end
            drop_cnt <= '0;
        end else begin
            if (set_yid) begin
                yid[0] <= yid_scan_in;
                for (int r = 1; r < ROWS; r++) begin
                    yid[r] <= yid[r-1];
                end
            end
            if (set_xid) begin
                xid[0] <= xid_scan_in;
                for (int k = 1; k < NPE; k++) begin
                    xid[k] <= xid[k-1];
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                if (push[r]) begin
                    wr_ptr[r] <= wr_ptr[r] + PTR_W'(1);
                end
                if (go[r]) begin
                    rd_ptr[r] <= rd_ptr[r] + PTR_W'(1);
                end
                if (push[r] && !go[r]) begin
                    count[r] <= count[r] + CNT_W'(1);
                end else if (go[r] && !push[r]) begin
                    count[r] <= count[r] - CNT_W'(1);
                end
            end
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // Storage needs no reset: the counts above decide what is visible.
    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (push[r]) begin
                mem[r][wr_ptr[r]] <= {tag_x, in_data};
            end
        end
    end

endmodule

// File: tb/tb_gin_buffered.sv
module tb_gin_buffered;

    localparam int DATA_W = 32;
    localparam int ROWS   = 6;
    localparam int COLS   = 8;
    localparam int NPE    = ROWS * COLS;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      in_data;
    logic [3:0]             tag_y;
    logic [4:0]             tag_x;
    logic                   set_yid;
    logic [3:0]             yid_scan_in;
    logic                   set_xid;
    logic [4:0]             xid_scan_in;
    logic [NPE-1:0]         pe_ready;
    logic [NPE-1:0]         pe_valid;
    logic [ROWS*DATA_W-1:0] pe_data;
    logic                   busy;
    logic [15:0]            drop_cnt;

    int vectors     = 0;
    int miscompares = 0;

    gin_buffered dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .tag_y       (tag_y),
        .tag_x       (tag_x),
        .set_yid     (set_yid),
        .yid_scan_in (yid_scan_in),
        .set_xid     (set_xid),
        .xid_scan_in (xid_scan_in),
        .pe_ready    (pe_ready),
        .pe_valid    (pe_valid),
        .pe_data     (pe_data),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Load PE IDs so that xid[k] = k % COLS, optionally with row 1 all zero.
    task automatic scan_x(input bit row1_zero);
        for (int k = NPE - 1; k >= 0; k--) begin
            xid_scan_in = (row1_zero && (k / COLS == 1)) ? 5'd0 : 5'(k % COLS);
            set_xid = 1'b1;
            tick();
        end
        set_xid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; tag_y = '0; tag_x = '0;
        set_yid = 1'b0; yid_scan_in = '0; set_xid = 1'b0; xid_scan_in = '0;
        pe_ready = '1;
        tick(); tick();
        check("rst_pe_valid", 64'(pe_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_pe_data", 64'(|pe_data), 64'd0);
        rst = 1'b1;

        // Row-ID chain: shift 5..0, expect yid[r] = r; scanning blocks input.
        for (int v = 5; v >= 0; v--) begin
            yid_scan_in = 4'(v);
            set_yid = 1'b1;
            #1;
            if (v == 5) check("scan_blocks_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        set_yid = 1'b0;
        for (int r = 0; r < ROWS; r++) check("yid_chain", 64'(dut.yid[r]), 64'(r));

        scan_x(1'b0);
        for (int k = 0; k < NPE; k++) check("xid_chain", 64'(dut.xid[k]), 64'(k % COLS));

        // Unicast row 2 col 3 -> PE 19.
        in_valid = 1'b1; tag_y = 4'd2; tag_x = 5'd3; in_data = 32'hA5;
        #1;
        check("uni_in_ready", 64'(in_ready), 64'd1);
        check("uni_no_early_valid", 64'(pe_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        #1;
        check("uni_pe_valid", 64'(pe_valid), 64'h1 << 19);
        check("uni_pe_data", 64'(pe_data[2*DATA_W +: DATA_W]), 64'hA5);
        check("uni_busy", 64'(busy), 64'd1);
        tick();
        check("uni_popped_valid", 64'(pe_valid), 64'd0);
        check("uni_popped_busy", 64'(busy), 64'd0);

        // Multicast to all of row 1.
        scan_x(1'b1);
        in_valid = 1'b1; tag_y = 4'd1; tag_x = 5'd0; in_data = 32'h11;
        tick();
        in_valid = 1'b0;
        #1;
        check("mc_pe_valid", 64'(pe_valid), 64'h0000_0000_FF00);
        check("mc_pe_data", 64'(pe_data[1*DATA_W +: DATA_W]), 64'h11);
        tick();
        check("mc_one_pop_valid", 64'(pe_valid), 64'd0);
        check("mc_one_pop_busy", 64'(busy), 64'd0);

        // Row 1 stalled by PE 9: four words fit, the fifth is refused.
        pe_ready = '1;
        pe_ready[9] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; tag_y = 4'd1; tag_x = 5'd0; in_data = 32'h100 + 32'(i);
            #1;
            check("bp_in_ready", 64'(in_ready), (i < 4) ? 64'd1 : 64'd0);
            check("bp_row1_hold", 64'(pe_valid[15:8]), 64'd0);
            if (i < 4) tick();
        end
        // Row 0 still takes traffic.
        tag_y = 4'd0; tag_x = 5'd5; in_data = 32'h77;
        #1;
        check("bp_row0_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("bp_row0_valid", 64'(pe_valid), 64'h1 << 5);
        check("bp_row0_data", 64'(pe_data[0 +: DATA_W]), 64'h77);
        // Release PE 9: the full row pops now but must still refuse input.
        pe_ready = '1;
        tag_y = 4'd1;
        #1;
        check("bp_no_popthrough", 64'(in_ready), 64'd0);
        check("bp_drain0_valid", 64'(pe_valid), 64'h0000_0000_FF20);
        check("bp_drain0_data", 64'(pe_data[1*DATA_W +: DATA_W]), 64'h100);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("bp_drain_valid", 64'(pe_valid), 64'h0000_0000_FF00);
            check("bp_drain_data", 64'(pe_data[1*DATA_W +: DATA_W]), 64'h100 + 64'(i));
        end
        tick();
        check("bp_drained_valid", 64'(pe_valid), 64'd0);
        check("bp_drained_busy", 64'(busy), 64'd0);
        check("bp_no_drops", 64'(drop_cnt), 64'd0);

        // No matching row: consumed and counted.
        in_valid = 1'b1; tag_y = 4'd15; tag_x = 5'd0; in_data = 32'hDEAD;
        #1;
        check("drop_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("drop_cnt_1", 64'(drop_cnt), 64'd1);
        check("drop_busy", 64'(busy), 64'd0);
        // Row 0 hit but no PE matches tag_x 31; dropped at the head.
        tag_y = 4'd0; tag_x = 5'd31;
        tick();
        check("hdrop_cnt_unchanged", 64'(drop_cnt), 64'd1);
        // Input drop and head drop in the same cycle add together.
        tag_y = 4'd15;
        #1;
        check("hdrop_no_valid", 64'(pe_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        check("drop_cnt_3", 64'(drop_cnt), 64'd3);
        check("drop_busy_after", 64'(busy), 64'd0);

        // Queue three words in row 2, then reset mid-operation.
        pe_ready = '0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; tag_y = 4'd2; tag_x = 5'd3; in_data = 32'hB0 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        check("fill_busy", 64'(busy), 64'd1);
        check("fill_count", 64'(dut.count[2]), 64'd3);
        rst = 1'b0;
        pe_ready = '1;
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valid", 64'(pe_valid), 64'd0);
        check("mid_rst_drop", 64'(drop_cnt), 64'd0);
        // All IDs are back to 0: tag 0/0 reaches every PE.
        in_valid = 1'b1; tag_y = 4'd0; tag_x = 5'd0; in_data = 32'hC3;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("post_rst_valid", 64'(pe_valid), 64'hFFFF_FFFF_FFFF);
        check("post_rst_data", 64'(pe_data[5*DATA_W +: DATA_W]), 64'hC3);
        tick();
        check("post_rst_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
